// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS channel encoder:
//   - CNT_W_DEF      default width of the signed running-disparity counter
//   - CTRL_*         10-bit control symbols sent during blanking, keyed by {c1,c0}
//   - sym_mode_e     which of the three data-symbol encodings stage 2 selects
//   - ones8()        population count of a byte
//   - ctrl_code()    {c1,c0} -> control symbol lookup
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam int CNT_W_DEF = 5;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    // Data-symbol encodings chosen by the disparity balancer:
    //   SYM_BAL  : no running bias (or balanced byte) -> q_m[8] decides inversion
    //   SYM_INV  : byte would worsen the running bias -> invert q_m[7:0]
    //   SYM_PASS : byte reduces the running bias      -> send q_m[7:0] as is
    typedef enum logic [1:0] {
        SYM_BAL  = 2'd0,
        SYM_INV  = 2'd1,
        SYM_PASS = 2'd2
    } sym_mode_e;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic c1, input logic c0);
        logic [9:0] code;
        case ({c1, c0})
            2'b00:   code = CTRL_00;
            2'b01:   code = CTRL_01;
            2'b10:   code = CTRL_10;
            default: code = CTRL_11;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tmds_if.sv
// -----------------------------------------------------------------------------
// tmds_if
// Pixel-side bundle of one TMDS channel.
//   de    data enable (1 = active video, 0 = blanking)
//   data  8-bit colour component, meaningful only while de=1
//   c0    control bit 0 (hsync on the blue channel, else 0)
//   c1    control bit 1 (vsync on the blue channel, else 0)
//   tmds  10-bit encoded symbol, bit 0 transmitted first
// master: sync generator / pixel source side.  slave: the encoder.
// -----------------------------------------------------------------------------
interface tmds_if;
    logic       de;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic [9:0] tmds;

    modport master (
        output de,
        output data,
        output c0,
        output c1,
        input  tmds
    );

    modport slave (
        input  de,
        input  data,
        input  c0,
        input  c1,
        output tmds
    );
endinterface

// File: rtl/tmds_qm.sv
// -----------------------------------------------------------------------------
// tmds_qm
// Combinational 8->9 transition minimiser.  Each output bit is the previous
// output bit XORed (or XNORed) with the next data bit, so the chain of q_m
// toggles only where the choice of operator makes it cheapest.  XNOR is chosen
// for bytes with many ones, which keeps the number of transitions in q_m[7:0]
// low.  q_m[8] records the operator (1 = XOR, 0 = XNOR) for the decoder.
// Ports:
//   data  input  8  colour byte
//   q_m   output 9  transition-minimised word
// -----------------------------------------------------------------------------
module tmds_qm
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output logic [8:0] q_m
);

    logic [3:0] n1;
    logic       use_xnor;
    logic [7:0] chain;

    always_comb begin
        n1       = ones8(data);
        // Tie-break at exactly four ones uses bit 0 so the choice is deterministic.
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
        chain    = 8'd0;
        chain[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : (chain[i-1] ^ data[i]);
        end
    end

    assign q_m = {~use_xnor, chain};

endmodule

// File: rtl/tmds_encoder.sv
// -----------------------------------------------------------------------------
// tmds_encoder
// One DVI/HDMI TMDS channel encoder, two register stages deep.
//   stage 1 : transition minimisation of the byte (tmds_qm), registered with
//             de/c0/c1
//   stage 2 : DC balancing against the running disparity counter, or a
//             control symbol during blanking; the result is the registered
//             output
// A full link uses three instances fed directly from the sync generator:
// blue with c0=hsync, c1=vsync; green and red with c0=c1=0.
// Ports:
//   clk_pix  input   pixel clock, all state updates on its rising edge
//   reset    input   synchronous, active-low; clears both stages, tmds=0x354
//   bus      slave   de / data / c0 / c1 in, tmds out (see tmds_if)
// Parameter:
//   CNT_W    width of the signed running-disparity counter (5..8); the
//            counter magnitude never exceeds 10, so no saturation is needed.
// -----------------------------------------------------------------------------
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic   clk_pix,
    input  logic   reset,
    tmds_if.slave  bus
);

    localparam logic signed [CNT_W-1:0] S_ZERO  = CNT_W'(0);
    localparam logic signed [CNT_W-1:0] S_TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] S_EIGHT = CNT_W'(8);

    logic       [8:0]       q_m_p0;

    logic                   de_p1;
    logic                   c0_p1;
    logic                   c1_p1;
    logic       [8:0]       q_m_p1;

    logic       [9:0]       tmds_p2;
    logic signed [CNT_W-1:0] cnt_p2;

    logic       [3:0]       n1_q;
    logic signed [CNT_W-1:0] n1_s;
    logic signed [CNT_W-1:0] n0_s;
    logic signed [CNT_W-1:0] diff_s;
    sym_mode_e              mode;
    logic       [9:0]       sym;
    logic signed [CNT_W-1:0] cnt_nxt;

    // ---- stage 0 -> 1 : transition minimisation ----------------------------
    tmds_qm u_qm (
        .data (bus.data),
        .q_m  (q_m_p0)
    );

    // ---- stage 1 -> 2 : DC balancing ---------------------------------------
    always_comb begin
        n1_q   = ones8(q_m_p1[7:0]);
        n1_s   = $signed({{(CNT_W-4){1'b0}}, n1_q});
        n0_s   = S_EIGHT - n1_s;
        diff_s = n1_s - n0_s;

        if ((cnt_p2 == S_ZERO) || (diff_s == S_ZERO)) begin
            mode = SYM_BAL;
        end else if (((cnt_p2 > S_ZERO) && (diff_s > S_ZERO)) ||
                     ((cnt_p2 < S_ZERO) && (diff_s < S_ZERO))) begin
            mode = SYM_INV;
        end else begin
            mode = SYM_PASS;
        end

        // Bits 9:8 of the symbol carry the inversion flag and q_m[8]; their
        // own imbalance is folded into the counter update (the +/-2 terms).
        case (mode)
            SYM_BAL: begin
                sym     = {~q_m_p1[8], q_m_p1[8],
                           q_m_p1[8] ? q_m_p1[7:0] : ~q_m_p1[7:0]};
                cnt_nxt = q_m_p1[8] ? (cnt_p2 + diff_s) : (cnt_p2 - diff_s);
            end
            SYM_INV: begin
                sym     = {1'b1, q_m_p1[8], ~q_m_p1[7:0]};
                cnt_nxt = cnt_p2 - diff_s + (q_m_p1[8] ? S_TWO : S_ZERO);
            end
            default: begin
                sym     = {1'b0, q_m_p1[8], q_m_p1[7:0]};
                cnt_nxt = cnt_p2 + diff_s - (q_m_p1[8] ? S_ZERO : S_TWO);
            end
        endcase
    end

    // ---- register stages ---------------------------------------------------
    // The whole datapath is cleared on reset so in-flight symbols are dropped
    // and the first symbol after reset is balanced from a zero counter.
    always_ff @(posedge clk_pix) begin
        if (!reset) begin
            de_p1   <= 1'b0;
            c0_p1   <= 1'b0;
            c1_p1   <= 1'b0;
            q_m_p1  <= 9'd0;
            tmds_p2 <= CTRL_00;
            cnt_p2  <= S_ZERO;
        end else begin
            de_p1  <= bus.de;
            c0_p1  <= bus.c0;
            c1_p1  <= bus.c1;
            q_m_p1 <= q_m_p0;
            if (de_p1) begin
                tmds_p2 <= sym;
                cnt_p2  <= cnt_nxt;
            end else begin
                // Blanking restarts DC balancing from zero for the next line.
                tmds_p2 <= ctrl_code(c1_p1, c0_p1);
                cnt_p2  <= S_ZERO;
            end
        end
    end

    assign bus.tmds = tmds_p2;

endmodule

// File: tb/tb_tmds_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder
// Directed vectors with hand-computed symbols and counter values, followed by
// a random segment checked against a small behavioural model and a decoder.
// Each step drives one input vector at the falling edge and checks the output
// expected for the vector driven two steps earlier (two register stages).
// -----------------------------------------------------------------------------
module tb_tmds_encoder;

    logic clk_pix = 1'b0;
    logic reset   = 1'b0;

    tmds_if bus ();

    tmds_encoder #(.CNT_W(5)) dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    int n_cmp = 0;
    int n_mis = 0;

    // Two-deep expectation pipeline; index 1 is due at the current step.
    logic       p_vld [2];
    logic       p_dec [2];
    logic [9:0] p_sym [2];
    int         p_cnt [2];
    logic [7:0] p_dat [2];
    string      p_tag [2];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] t);
        logic [7:0] q;
        logic [7:0] d;
        q    = t[9] ? ~t[7:0] : t[7:0];
        d    = 8'd0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = t[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    // Reference encoder; the new disparity is taken from the emitted symbol.
    task automatic model(input logic [7:0] d, input int rd,
                         output logic [9:0] sym, output int rd_n);
        int         n1;
        int         ones;
        int         bal;
        logic       xn;
        logic [7:0] q;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q    = 8'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(q[i]);
        bal = 2 * ones - 8;
        if (rd == 0 || bal == 0)
            sym = xn ? {2'b10, ~q} : {2'b01, q};
        else if ((rd > 0 && bal > 0) || (rd < 0 && bal < 0))
            sym = {1'b1, ~xn, ~q};
        else
            sym = {1'b0, ~xn, q};
        ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(sym[i]);
        rd_n = rd + 2 * ones - 10;
    endtask

    task automatic step(input logic rst_i, input logic de_i, input logic [7:0] d,
                        input logic [1:0] c, input logic chk, input logic [9:0] sym,
                        input int cnt, input logic dec, input string tag);
        @(negedge clk_pix);
        if (p_vld[1]) begin
            check({p_tag[1], "_sym"}, 32'(bus.tmds), 32'(p_sym[1]));
            check({p_tag[1], "_cnt"}, int'(dut.cnt_p2), p_cnt[1]);
            if (p_dec[1]) check({p_tag[1], "_dec"}, 32'(decode(bus.tmds)), 32'(p_dat[1]));
        end
        p_vld[1] = p_vld[0]; p_dec[1] = p_dec[0]; p_sym[1] = p_sym[0];
        p_cnt[1] = p_cnt[0]; p_dat[1] = p_dat[0]; p_tag[1] = p_tag[0];
        p_vld[0] = chk; p_dec[0] = dec; p_sym[0] = sym;
        p_cnt[0] = cnt; p_dat[0] = d;   p_tag[0] = tag;
        reset    = rst_i;
        bus.de   = de_i;
        bus.data = d;
        bus.c0   = c[0];
        bus.c1   = c[1];
    endtask

    initial begin
        logic [9:0] rsym;
        int         rd;
        int         rd_n;
        logic       rde;
        logic [7:0] rdat;
        logic [1:0] rc;

        for (int i = 0; i < 2; i++) begin
            p_vld[i] = 1'b0; p_dec[i] = 1'b0; p_sym[i] = 10'd0;
            p_cnt[i] = 0;    p_dat[i] = 8'd0; p_tag[i] = "";
        end
        bus.de = 1'b0; bus.data = 8'd0; bus.c0 = 1'b0; bus.c1 = 1'b0;

        // Reset held, then released: 0x354 through the pipeline drain.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0, 1'b0, "rst");

        // Control symbols, with data deliberately non-zero.
        step(1'b1, 1'b0, 8'hA5, 2'b00, 1'b1, 10'h354, 0, 1'b0, "ctl00");
        step(1'b1, 1'b0, 8'h5A, 2'b01, 1'b1, 10'h0AB, 0, 1'b0, "ctl01");
        step(1'b1, 1'b0, 8'hFF, 2'b10, 1'b1, 10'h154, 0, 1'b0, "ctl10");
        step(1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB, 0, 1'b0, "ctl11");

        // 0x00 twice (control bits ignored while de=1), then blanking clears cnt.
        step(1'b1, 1'b1, 8'h00, 2'b11, 1'b1, 10'h100, -8, 1'b1, "zero0");
        step(1'b1, 1'b1, 8'h00, 2'b11, 1'b1, 10'h3FF,  2, 1'b1, "zero1");
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354,  0, 1'b0, "blank0");
        step(1'b1, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h200, -8, 1'b1, "ones");
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354,  0, 1'b0, "blank1");

        // de toggling every cycle.
        step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, 1'b1, "tgl_d0");
        step(1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB,  0, 1'b0, "tgl_c0");
        step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, 1'b1, "tgl_d1");
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354,  0, 1'b0, "tgl_c1");

        // Four-ones tie-break, every balancing branch, balanced bytes at cnt!=0.
        step(1'b1, 1'b1, 8'h0F, 2'b00, 1'b1, 10'h105, -4, 1'b1, "b0F_a");
        step(1'b1, 1'b1, 8'hF0, 2'b00, 1'b1, 10'h0FA, -2, 1'b1, "bF0_a");
        step(1'b1, 1'b1, 8'h0F, 2'b00, 1'b1, 10'h3FA,  4, 1'b1, "b0F_b");
        step(1'b1, 1'b1, 8'hF0, 2'b00, 1'b1, 10'h205,  0, 1'b1, "bF0_b");
        step(1'b1, 1'b1, 8'hF0, 2'b00, 1'b1, 10'h205, -4, 1'b1, "bF0_c");
        step(1'b1, 1'b1, 8'hAA, 2'b00, 1'b1, 10'h233, -4, 1'b1, "bAA");
        step(1'b1, 1'b1, 8'h55, 2'b00, 1'b1, 10'h133, -4, 1'b1, "b55");
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354,  0, 1'b0, "blank2");

        // One-cycle reset mid-line: in-flight symbol dropped, restart from cnt=0.
        step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, 1'b1, "pre0");
        step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354,  0, 1'b0, "rst_drop");
        step(1'b0, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h354,  0, 1'b0, "rst_hold");
        step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8, 1'b1, "post0");
        step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF,  2, 1'b1, "post1");
        step(1'b1, 1'b0, 8'h00, 2'b10, 1'b1, 10'h154,  0, 1'b0, "blank3");

        // Random data and de against the model.
        rd = 0;
        for (int i = 0; i < 2000; i++) begin
            rde  = ($urandom_range(0, 3) != 0);
            rdat = 8'($urandom);
            rc   = 2'($urandom);
            if (rde) begin
                model(rdat, rd, rsym, rd_n);
                rd = rd_n;
            end else begin
                rsym = ctl_sym(rc);
                rd   = 0;
            end
            step(1'b1, rde, rdat, rc, 1'b1, rsym, rd, rde, "rnd");
        end

        // Drain the last two expectations.
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 10'h354, 0, 1'b0, "flush");
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 10'h354, 0, 1'b0, "flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 Parameter: CNT_W, default 5, signed width of running-disparity counter; legal range 5..8.
REQ-002 clk_pix  input  1  pixel clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 de  input  1  data enable from sync generator; 1 = active video, 0 = blanking.
REQ-005 data  input  8  pixel colour component, meaningful only when de=1.
REQ-006 c0  input  1  control bit 0 (hsync on blue channel, else 0).
REQ-007 c1  input  1  control bit 1 (vsync on blue channel, else 0).
REQ-008 tmds  output  10  registered TMDS symbol, bit 0 transmitted first.

Function
REQ-009 Pipeline SHALL have exactly 2 register stages; inputs sampled at edge k appear on tmds after edge k+2; throughput one symbol per clk_pix.
REQ-010 Stage 1 SHALL register de, c0, c1 and q_m[8:0] computed from data.
REQ-011 Stage 1 SHALL pick XNOR mode when N1(data)>4, or N1(data)==4 and data[0]==0; otherwise XOR mode.
REQ-012 q_m[0]=data[0]; q_m[i]=q_m[i-1] XOR/XNOR data[i] for i=1..7; q_m[8]=1 for XOR, 0 for XNOR.
REQ-013 Stage 2, de=0: tmds SHALL be {c1,c0}: 00->0x354, 01->0x0AB, 10->0x154, 11->0x2AB; cnt SHALL clear to 0.
REQ-014 Stage 2, de=1, cnt==0 or N1(q_m[7:0])==N0(q_m[7:0]): tmds={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8]?(N1-N0):(N0-N1).
REQ-015 Stage 2, de=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1): tmds={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
REQ-016 Stage 2, de=1, all other cases: tmds={0, q_m[8], q_m[7:0]}; cnt += (N1-N0) - 2*(~q_m[8]).
REQ-017 N1/N0 in stage 2 SHALL count q_m[7:0] only; all disparity arithmetic signed CNT_W bits; |cnt| never exceeds 10 so no saturation logic.
REQ-018 de toggling every cycle SHALL be handled without bubbles; each symbol uses cnt left by immediately preceding symbol.
REQ-019 data, c0, c1 SHALL have no effect on cnt while de=0; c0/c1 SHALL have no effect on tmds while de=1.

Reset
REQ-020 While reset=0 at a rising edge: stage-1 registers SHALL clear (de=0, c0=c1=0, q_m=0), cnt SHALL be 0, tmds SHALL be 0x354.
REQ-021 Reset asserted mid-active-line SHALL discard in-flight symbols; first post-reset symbol SHALL be encoded with cnt=0.
REQ-022 After reset deasserts, tmds SHALL stay 0x354 for 2 cycles, then follow inputs per REQ-009.

Structure
REQ-023 Shared package tmds_pkg SHALL hold the four control-code constants and the CNT_W default.
REQ-024 Stage 1 SHALL be sub-module tmds_qm (combinational 8->9 transition minimiser); stage 2 and registers stay in tmds_encoder.
REQ-025 Three instances (blue with c0=hsync, c1=vsync; green, red with c0=c1=0) SHALL consume de/hsync/vsync directly from the sync generator.

Verification
REQ-026 Reset, then de=0, {c1,c0} cycling 00,01,10,11 -> tmds 0x354,0x0AB,0x154,0x2AB, each 2 cycles after input.
REQ-027 Reset, de=1, data=0x00 two consecutive cycles -> tmds 0x100 then 0x3FF; cnt -8 then +2.
REQ-028 Reset, de=1, data=0xFF from cnt=0 -> tmds 0x200, cnt=-8.
REQ-029 Random data with random de for 10^5 cycles -> reference-model match every symbol; cnt returns to 0 after each de=0 cycle; decoded byte equals input.
REQ-030 Reset pulsed for one cycle mid-line with de=1 -> tmds 0x354 during reset and next 2 cycles; next symbol matches model from cnt=0.
